// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-mapped controller.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  localparam logic [7:0] STATUS_BYTE = 8'hA5;
  localparam logic [7:0] MODE_RESET  = 8'h04;

  localparam int MODE_CPOL_BIT = 0;
  localparam int MODE_CPHA_BIT = 1;
  localparam int MODE_MSB_BIT  = 2;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;

  function automatic logic addr_ok(input logic [CMD_ADDR_W-1:0] a, input int num_regs);
    return 32'(a) < 32'(num_regs);
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// SPI-side byte stream and host register port of spi_reg_ctrl.
interface spi_reg_ctrl_if;
  import spi_reg_ctrl_pkg::*;

  logic                  spi_cs;
  logic [7:0]            spi_data_in;
  logic                  spi_end_of_byte;
  logic                  spi_busy;
  logic [7:0]            spi_data_out;
  logic                  spi_cpol;
  logic                  spi_cpha;
  logic                  spi_msb_first;
  logic [CMD_ADDR_W-1:0] host_addr;
  logic                  host_wr;
  logic [7:0]            host_wdata;
  logic [7:0]            host_rdata;
  logic                  spi_err;

  modport slave (
    input  spi_cs, spi_data_in, spi_end_of_byte, spi_busy,
    input  host_addr, host_wr, host_wdata,
    output spi_data_out, spi_cpol, spi_cpha, spi_msb_first,
    output host_rdata, spi_err
  );

  modport master (
    output spi_cs, spi_data_in, spi_end_of_byte, spi_busy,
    output host_addr, host_wr, host_wdata,
    input  spi_data_out, spi_cpol, spi_cpha, spi_msb_first,
    input  host_rdata, spi_err
  );

endinterface

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8 register bank: SPI write beats host write on the same address,
// two combinational read ports returning 0x00 for out-of-range addresses.
module spi_reg_bank
  import spi_reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = CMD_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_spi_we,
  input  logic [ADDR_W-1:0] i_spi_addr,
  input  logic [7:0]        i_spi_wdata,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  output logic [7:0]        o_rd_a_data,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  output logic [7:0]        o_rd_b_data,
  output logic [2:0]        o_mode
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [7:0] r_regs [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam logic [7:0] RST_VAL = (g == 0) ? MODE_RESET : 8'h00;
    logic w_spi_hit;
    logic w_host_hit;

    assign w_spi_hit  = i_spi_we  && (i_spi_addr  == ADDR_W'(g));
    assign w_host_hit = i_host_we && (i_host_addr == ADDR_W'(g));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)            r_regs[g] <= RST_VAL;
      else if (w_spi_hit)  r_regs[g] <= i_spi_wdata;
      else if (w_host_hit) r_regs[g] <= i_host_wdata;
    end
  end

  always_comb begin
    o_rd_a_data = 8'h00;
    if (addr_ok(i_rd_a_addr, NUM_REGS)) o_rd_a_data = r_regs[i_rd_a_addr[IDX_W-1:0]];
  end

  always_comb begin
    o_rd_b_data = 8'h00;
    if (addr_ok(i_rd_b_addr, NUM_REGS)) o_rd_b_data = r_regs[i_rd_b_addr[IDX_W-1:0]];
  end

  assign o_mode = {r_regs[0][MODE_MSB_BIT], r_regs[0][MODE_CPHA_BIT], r_regs[0][MODE_CPOL_BIT]};

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command/data sequencer turning spi_slave bytes into register reads/writes.
// Optional frame-write interrupt enabled by SPI_REG_CTRL_IRQ_EN.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = CMD_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  spi_reg_ctrl_if.slave bus
`ifdef SPI_REG_CTRL_IRQ_EN
  ,
  output logic          irq,
  input  logic          irq_clr
`endif
);

  state_e            r_state, w_state_nxt;
  logic              r_cs_q;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        r_data_out;
  logic [7:0]        w_rd_data;
  logic [2:0]        w_mode;
  logic              r_err;
  logic              r_cpol, r_cpha, r_msb;
  logic              w_eob, w_cs_fall;
  logic              w_cmd_eob, w_wr_eob, w_rd_eob;
  logic              w_ptr_ok, w_rd_ok;
  logic              w_spi_we, w_rd_load, w_err_set, w_host_clr;

  assign w_eob     = bus.spi_end_of_byte;
  assign w_cs_fall = r_cs_q && !bus.spi_cs;
  assign w_cmd_eob = w_eob && (r_state == CMD);
  assign w_wr_eob  = w_eob && (r_state == WR_DATA);
  assign w_rd_eob  = w_eob && (r_state == RD_DATA);

  // Wrap at the last register; out-of-range pointers run on to 127 then 0.
  assign w_ptr_inc = (32'(r_ptr) == 32'(NUM_REGS - 1)) ? '0 : r_ptr + ADDR_W'(1);
  assign w_rd_addr = w_cmd_eob ? bus.spi_data_in[ADDR_W-1:0] : w_ptr_inc;

  assign w_ptr_ok   = addr_ok(r_ptr, NUM_REGS);
  assign w_rd_ok    = addr_ok(w_rd_addr, NUM_REGS);
  assign w_spi_we   = w_wr_eob && w_ptr_ok;
  assign w_rd_load  = (w_cmd_eob && bus.spi_data_in[CMD_RW_BIT]) || w_rd_eob;
  assign w_err_set  = (w_wr_eob && !w_ptr_ok) || (w_rd_load && !w_rd_ok);
  assign w_host_clr = bus.host_wr && (bus.host_addr == ADDR_W'(1));

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .i_spi_we     (w_spi_we),
    .i_spi_addr   (r_ptr),
    .i_spi_wdata  (bus.spi_data_in),
    .i_host_we    (bus.host_wr),
    .i_host_addr  (bus.host_addr),
    .i_host_wdata (bus.host_wdata),
    .i_rd_a_addr  (bus.host_addr),
    .o_rd_a_data  (bus.host_rdata),
    .i_rd_b_addr  (w_rd_addr),
    .o_rd_b_data  (w_rd_data),
    .o_mode       (w_mode)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = CMD;
      CMD:     if (w_eob) w_state_nxt = bus.spi_data_in[CMD_RW_BIT] ? RD_DATA : WR_DATA;
      WR_DATA: w_state_nxt = WR_DATA;
      RD_DATA: w_state_nxt = RD_DATA;
      default: w_state_nxt = IDLE;
    endcase
    // Frame end overrides everything, after the same-cycle byte is processed.
    if (bus.spi_cs && (r_state != IDLE)) w_state_nxt = IDLE;
  end

  // r_cs_q resets low so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cs_q     <= 1'b0;
      r_ptr      <= '0;
      r_data_out <= STATUS_BYTE;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs_q  <= bus.spi_cs;
      if (w_cmd_eob)                 r_ptr <= bus.spi_data_in[ADDR_W-1:0];
      else if (w_wr_eob || w_rd_eob) r_ptr <= w_ptr_inc;
      if (w_state_nxt != RD_DATA)    r_data_out <= STATUS_BYTE;
      else if (w_rd_load)            r_data_out <= w_rd_data;
      if (w_err_set)                 r_err <= 1'b1;
      else if (w_host_clr)           r_err <= 1'b0;
    end
  end

  // Mode is shadowed for the whole frame; it follows reg0 only while deselected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpol <= MODE_RESET[MODE_CPOL_BIT];
      r_cpha <= MODE_RESET[MODE_CPHA_BIT];
      r_msb  <= MODE_RESET[MODE_MSB_BIT];
    end else if (bus.spi_cs) begin
      r_cpol <= w_mode[0];
      r_cpha <= w_mode[1];
      r_msb  <= w_mode[2];
    end
  end

  assign bus.spi_data_out  = r_data_out;
  assign bus.spi_cpol      = r_cpol;
  assign bus.spi_cpha      = r_cpha;
  assign bus.spi_msb_first = r_msb;
  assign bus.spi_err       = r_err;

`ifdef SPI_REG_CTRL_IRQ_EN
  logic w_cs_rise;
  logic r_wr_seen;
  logic r_irq;

  assign w_cs_rise = !r_cs_q && bus.spi_cs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_seen <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_cs_rise)     r_wr_seen <= 1'b0;
      else if (w_spi_we) r_wr_seen <= 1'b1;
      if (w_cs_rise && (r_wr_seen || w_spi_we)) r_irq <= 1'b1;
      else if (irq_clr)                         r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

  a_busy_in_frame: assert property (@(posedge clk) disable iff (!rst)
    bus.spi_busy |-> !bus.spi_cs);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomised scoreboard bench for spi_reg_ctrl against an array-based register model.
module tb_spi_reg_ctrl;
  import spi_reg_ctrl_pkg::*;

  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_reg_ctrl_if bus();

`ifdef SPI_REG_CTRL_IRQ_EN
  logic irq;
  logic irq_clr = 1'b0;
`endif

  spi_reg_ctrl #(.NUM_REGS(NR), .ADDR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SPI_REG_CTRL_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [NR];
  bit         mdl_err;
  logic [7:0] exp_q [$];
  bit         mon_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: the byte presented after every end_of_byte must match the queue head.
  always @(negedge clk) begin
    if (mon_pend) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got %0h expected none", bus.spi_data_out);
      end else begin
        chk("spi_data_out", 32'(bus.spi_data_out), 32'(exp_q.pop_front()));
      end
    end
    mon_pend = bus.spi_end_of_byte && rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nxt(input int a);
    return (a == NR - 1) ? 0 : (a + 1) % 128;
  endfunction

  function automatic logic [7:0] rd_model(input int a);
    if (a < NR) return mdl[a];
    mdl_err = 1'b1;
    return 8'h00;
  endfunction

  function automatic void wr_model(input int a, input logic [7:0] d);
    if (a < NR) mdl[a] = d;
    else        mdl_err = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
    mdl[0]  = MODE_RESET;
    mdl_err = 1'b0;
  endfunction

  task automatic send_byte(input logic [7:0] v, input logic [7:0] e);
    bus.spi_busy = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    bus.spi_busy        = 1'b0;
    bus.spi_end_of_byte = 1'b1;
    bus.spi_data_in     = v;
    exp_q.push_back(e);
    tick();
    bus.spi_end_of_byte = 1'b0;
    tick();
  endtask

  task automatic do_host_write(input int a, input logic [7:0] d);
    bus.host_wr    = 1'b1;
    bus.host_addr  = 7'(a);
    bus.host_wdata = d;
    tick();
    bus.host_wr = 1'b0;
    if (a < NR) mdl[a] = d;
    if (a == 1) mdl_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] m;
    tick();
    for (int i = 0; i < NR; i++) begin
      bus.host_addr = 7'(i);
      #1;
      chk({tag, "_reg"}, 32'(bus.host_rdata), 32'(mdl[i]));
    end
    m = mdl[0];
    chk({tag, "_err"},  32'(bus.spi_err),       32'(mdl_err));
    chk({tag, "_cpol"}, 32'(bus.spi_cpol),      32'(m[0]));
    chk({tag, "_cpha"}, 32'(bus.spi_cpha),      32'(m[1]));
    chk({tag, "_msb"},  32'(bus.spi_msb_first), 32'(m[2]));
  endtask

  task automatic run_frame(input logic [7:0] fb [$]);
    int a;
    logic [7:0] c, e;
    bus.spi_cs = 1'b0;
    tick();
    chk("frame_start_status", 32'(bus.spi_data_out), 32'(STATUS_BYTE));
    c = fb[0];
    a = int'(c[6:0]);
    for (int i = 0; i < fb.size(); i++) begin
      e = STATUS_BYTE;
      if (i == 0) begin
        if (c[7]) e = rd_model(a);
      end else if (c[7]) begin
        a = nxt(a);
        e = rd_model(a);
      end else begin
        wr_model(a, fb[i]);
        a = nxt(a);
      end
      send_byte(fb[i], e);
    end
    bus.spi_cs = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] fb [$];
    logic [7:0] v;
    int a, n;

    bus.spi_cs = 1'b1; bus.spi_data_in = 8'h00; bus.spi_end_of_byte = 1'b0;
    bus.spi_busy = 1'b0; bus.host_addr = '0; bus.host_wr = 1'b0; bus.host_wdata = 8'h00;
    model_reset();

    repeat (3) tick();
    chk("rst_data_out", 32'(bus.spi_data_out),  32'(STATUS_BYTE));
    chk("rst_cpol",     32'(bus.spi_cpol),      32'(0));
    chk("rst_cpha",     32'(bus.spi_cpha),      32'(0));
    chk("rst_msb",      32'(bus.spi_msb_first), 32'(1));
    chk("rst_err",      32'(bus.spi_err),       32'(0));
    rst = 1'b1;
    check_all("reset");
    bus.host_addr = 7'd100;
    #1;
    chk("host_oob_read", 32'(bus.host_rdata), 32'(0));

    fb = {8'h03, 8'h11, 8'h22, 8'h33};
    run_frame(fb);
    check_all("burst");
`ifdef SPI_REG_CTRL_IRQ_EN
    chk("irq_set", 32'(irq), 32'(1));
    irq_clr = 1'b1; tick(); irq_clr = 1'b0; tick();
    chk("irq_clr", 32'(irq), 32'(0));
`endif

    fb = {8'h20, 8'h77};
    run_frame(fb);
    check_all("oob_write");
`ifdef SPI_REG_CTRL_IRQ_EN
    chk("irq_oob_quiet", 32'(irq), 32'(0));
`endif
    do_host_write(1, 8'h3C);
    check_all("err_clear");

    do_host_write(15, 8'h5F);
    do_host_write(0, 8'h04);
    fb = {8'h8F, 8'h00, 8'h00};
    run_frame(fb);
    check_all("read_wrap");

    // Mid-frame reg0 write must not reach the mode outputs until deselect.
    bus.spi_cs = 1'b0;
    tick();
    send_byte(8'h00, STATUS_BYTE);
    send_byte(8'h00, STATUS_BYTE);
    mdl[0] = 8'h00;
    tick();
    chk("shadow_mid_msb", 32'(bus.spi_msb_first), 32'(1));
    bus.spi_cs = 1'b1;
    #1;
    chk("shadow_rise_msb", 32'(bus.spi_msb_first), 32'(1));
    tick();
    chk("shadow_after_msb",  32'(bus.spi_msb_first), 32'(0));
    chk("shadow_after_cpol", 32'(bus.spi_cpol),      32'(0));
    chk("shadow_after_cpha", 32'(bus.spi_cpha),      32'(0));
    check_all("shadow");

    // Abort inside the first data byte.
    bus.spi_cs = 1'b0;
    tick();
    send_byte(8'h02, STATUS_BYTE);
    bus.spi_busy = 1'b1;
    repeat (4) tick();
    bus.spi_busy = 1'b0;
    bus.spi_cs   = 1'b1;
    tick(); tick();
    chk("abort_status", 32'(bus.spi_data_out), 32'(STATUS_BYTE));
    check_all("abort");

    // Same-cycle host and SPI write to reg2.
    bus.spi_cs = 1'b0;
    tick();
    send_byte(8'h02, STATUS_BYTE);
    bus.spi_busy = 1'b1;
    tick(); tick();
    bus.spi_busy = 1'b0;
    bus.spi_end_of_byte = 1'b1; bus.spi_data_in = 8'h44;
    bus.host_wr = 1'b1; bus.host_addr = 7'd2; bus.host_wdata = 8'h99;
    exp_q.push_back(STATUS_BYTE);
    tick();
    bus.spi_end_of_byte = 1'b0; bus.host_wr = 1'b0;
    tick();
    mdl[2] = 8'h44;
    bus.spi_cs = 1'b1;
    tick(); tick();
    check_all("collision");

    // Reset while streaming read data.
    bus.spi_cs = 1'b0;
    tick();
    v = rd_model(15);
    send_byte(8'h8F, v);
    v = rd_model(0);
    send_byte(8'h00, v);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_data_out", 32'(bus.spi_data_out), 32'(STATUS_BYTE));
    bus.host_addr = 7'd0;
    #1;
    chk("midrst_reg0", 32'(bus.host_rdata), 32'(MODE_RESET));
    model_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
    send_byte(8'h03, STATUS_BYTE);
    bus.spi_cs = 1'b1;
    tick(); tick();
    check_all("midrst");

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 9);
      if (n < 7)      a = $urandom_range(0, NR - 1);
      else if (n < 9) a = $urandom_range(NR, 127);
      else            a = $urandom_range(125, 127);
      v = {1'($urandom_range(0, 1)), 7'(a)};
      fb = {v};
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      run_frame(fb);
      check_all("rand");
      if (mdl_err && ($urandom_range(0, 1) == 1)) do_host_write(1, 8'($urandom));
    end

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
